// File: rtl/usb_phy_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : usb_phy_pkg
//  Purpose  : Shared line-state and monitor-state types, default timing
//             constants and the J/K/SE0/SE1 decode helper.
//  Revision : 1.0 - initial release
// ============================================================================
package usb_phy_pkg;

  typedef enum logic [1:0] {
    LS_SE0 = 2'b00,
    LS_K   = 2'b01,
    LS_J   = 2'b10,
    LS_SE1 = 2'b11
  } line_state_e;

  typedef enum logic [1:0] {
    ST_ACTIVE  = 2'd0,
    ST_RESET   = 2'd1,
    ST_SUSPEND = 2'd2
  } lsm_state_e;

  // Defaults assume a 60 MHz PHY clock.
  localparam int c_def_sync_stages       = 2;
  localparam int c_def_filter_cycles     = 2;
  localparam int c_def_squelch_threshold = 3;
  localparam int c_def_reset_cycles      = 150;
  localparam int c_def_suspend_cycles    = 180000;

  // Raw {dp,dn} to bus state. Low speed swaps J and K; HS overrides LS.
  function automatic line_state_e decode_line(input logic [1:0] raw,
                                              input logic       hs,
                                              input logic       ls);
    case (raw)
      2'b00:   return LS_SE0;
      2'b11:   return LS_SE1;
      2'b10:   return (ls && !hs) ? LS_K : LS_J;
      default: return (ls && !hs) ? LS_J : LS_K;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/line_sync_filter.sv
`default_nettype none
// ============================================================================
//  Module   : line_sync_filter
//  Purpose  : Synchronises asynchronous D+/D- and suppresses glitches shorter
//             than FILTER_CYCLES synchronised samples.
//  Revision : 1.0 - initial release
// ============================================================================
module line_sync_filter #(
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 2
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_dp,
  input  logic       i_dn,
  output logic [1:0] o_raw,
  output logic       o_change
);

  localparam int FCNT_W = $clog2(FILTER_CYCLES + 1);
  localparam logic [FCNT_W-1:0] c_filter_max = FCNT_W'(FILTER_CYCLES);

  // r_sync[0] is the newest sample, r_sync[SYNC_STAGES-1] the safe one.
  logic [SYNC_STAGES-1:0][1:0] r_sync;
  logic [1:0]                  w_sync;
  logic [1:0]                  r_cand;
  logic [1:0]                  r_filt;
  logic [FCNT_W-1:0]           r_cnt;
  logic [FCNT_W-1:0]           w_cnt_next;
  logic                        w_update;
  logic                        r_change;

  assign w_sync   = r_sync[SYNC_STAGES-1];
  assign o_raw    = r_filt;
  assign o_change = r_change;

  // Shift the pin pair through the synchroniser chain.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_sync <= '0;
    else          r_sync <= {r_sync[SYNC_STAGES-2:0], {i_dp, i_dn}};
  end

  // Run length of the current synchronised value, saturating at the target.
  always_comb begin
    if (w_sync != r_cand)            w_cnt_next = FCNT_W'(1);
    else if (r_cnt == c_filter_max)  w_cnt_next = r_cnt;
    else                             w_cnt_next = r_cnt + FCNT_W'(1);
    w_update = (w_cnt_next == c_filter_max) && (w_sync != r_filt);
  end

  // Track candidate/count and commit a stable candidate as the filtered value.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cand   <= 2'b00;
      r_cnt    <= '0;
      r_filt   <= 2'b00;
      r_change <= 1'b0;
    end else begin
      r_cand   <= w_sync;
      r_cnt    <= w_cnt_next;
      r_change <= w_update;
      if (w_update) r_filt <= w_sync;
    end
  end

endmodule
`default_nettype wire

// File: rtl/line_state_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : line_state_monitor
//  Purpose  : Filtered USB line-state decode with squelch, bus-reset,
//             suspend and resume detection for the link/UTMI layer.
//  Revision : 1.0 - initial release
// ============================================================================
module line_state_monitor
  import usb_phy_pkg::*;
#(
  parameter int SYNC_STAGES       = c_def_sync_stages,
  parameter int FILTER_CYCLES     = c_def_filter_cycles,
  parameter int SQUELCH_THRESHOLD = c_def_squelch_threshold,
  parameter int RESET_CYCLES      = c_def_reset_cycles,
  parameter int SUSPEND_CYCLES    = c_def_suspend_cycles
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_dp,
  input  logic       i_dn,
  input  logic       i_hs_mode,
  input  logic       i_ls_mode,
  output logic [1:0] o_line_state,
  output logic       o_se0,
  output logic       o_se1,
  output logic       o_j_state,
  output logic       o_k_state,
  output logic       o_ls_change,
  output logic       o_squelch,
  output logic       o_bus_reset,
  output logic       o_in_reset,
  output logic       o_suspend,
  output logic       o_resume
);

  localparam int CNT_W = $clog2(SUSPEND_CYCLES + 1);
  localparam logic [CNT_W-1:0] c_cnt_max     = '1;
  localparam logic [CNT_W-1:0] c_squelch_cnt = CNT_W'(SQUELCH_THRESHOLD);
  localparam logic [CNT_W-1:0] c_reset_cnt   = CNT_W'(RESET_CYCLES);
  localparam logic [CNT_W-1:0] c_suspend_cnt = CNT_W'(SUSPEND_CYCLES);

  logic [1:0]       w_raw;
  logic             w_change;
  line_state_e      w_state;
  logic [CNT_W-1:0] r_dur_cnt;
  logic [CNT_W-1:0] w_dur_cnt;
  lsm_state_e       r_state;
  logic             r_squelch;
  logic             r_bus_reset;
  logic             r_resume;

  line_sync_filter #(
    .SYNC_STAGES   (SYNC_STAGES),
    .FILTER_CYCLES (FILTER_CYCLES)
  ) u_sync_filter (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_dp     (i_dp),
    .i_dn     (i_dn),
    .o_raw    (w_raw),
    .o_change (w_change)
  );

  // Decode follows the mode pins directly, so a mode flip never looks like a
  // line change.
  assign w_state      = decode_line(w_raw, i_hs_mode, i_ls_mode);
  assign o_line_state = w_state;
  assign o_se0        = (w_state == LS_SE0);
  assign o_se1        = (w_state == LS_SE1);
  assign o_j_state    = (w_state == LS_J);
  assign o_k_state    = (w_state == LS_K);
  assign o_ls_change  = w_change;
  assign o_squelch    = r_squelch;
  assign o_bus_reset  = r_bus_reset;
  assign o_resume     = r_resume;
  assign o_in_reset   = (r_state == ST_RESET);
  assign o_suspend    = (r_state == ST_SUSPEND);

  // Duration of the current filtered state: reads 1 in the cycle the new state
  // first appears, so a change always pre-empts any threshold match.
  assign w_dur_cnt = w_change ? CNT_W'(1) : r_dur_cnt;

  // Advance the duration counter, holding at all-ones.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                    r_dur_cnt <= '0;
    else if (w_dur_cnt != c_cnt_max) r_dur_cnt <= w_dur_cnt + CNT_W'(1);
    else                             r_dur_cnt <= c_cnt_max;
  end

  // HS squelch: SE0 that has lasted at least the threshold.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_squelch <= 1'b0;
    else          r_squelch <= i_hs_mode && (w_state == LS_SE0) &&
                               (w_dur_cnt >= c_squelch_cnt);
  end

  // Bus-reset / suspend / resume sequencing.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_ACTIVE;
      r_bus_reset <= 1'b0;
      r_resume    <= 1'b0;
    end else begin
      r_bus_reset <= 1'b0;
      r_resume    <= 1'b0;
      case (r_state)
        ST_ACTIVE: begin
          if (w_state == LS_SE0 && w_dur_cnt == c_reset_cnt) begin
            r_state     <= ST_RESET;
            r_bus_reset <= 1'b1;
          end else if (w_state == LS_J && !i_hs_mode &&
                       w_dur_cnt == c_suspend_cnt) begin
            r_state <= ST_SUSPEND;
          end
        end
        ST_RESET: begin
          if (w_state != LS_SE0) r_state <= ST_ACTIVE;
        end
        ST_SUSPEND: begin
          // Only K is a resume; SE0/SE1 just drop suspend and get timed afresh.
          if (w_state != LS_J) begin
            r_state  <= ST_ACTIVE;
            r_resume <= (w_state == LS_K);
          end
        end
        default: r_state <= ST_ACTIVE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_line_state_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_line_state_monitor
//  Purpose  : Self-checking bench for line_state_monitor against a
//             pin-history reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_line_state_monitor;

  localparam int S       = 2;
  localparam int F       = 2;
  localparam int SQ      = 3;
  localparam int RST_C   = 8;
  localparam int SUSP    = 20;
  localparam int DUR_MAX = 31;

  logic i_clk = 1'b0;
  logic i_rst_n = 1'b0;
  logic i_dp = 1'b0;
  logic i_dn = 1'b0;
  logic i_hs_mode = 1'b0;
  logic i_ls_mode = 1'b0;
  logic [1:0] o_line_state;
  logic o_se0, o_se1, o_j_state, o_k_state, o_ls_change, o_squelch;
  logic o_bus_reset, o_in_reset, o_suspend, o_resume;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [1:0] m_filt;
  int         m_dur;
  logic       m_change, m_squelch, m_bus_reset, m_in_reset, m_suspend, m_resume;
  logic [1:0] pin_q[$];
  logic [1:0] flt_q[$];

  always #5 i_clk = ~i_clk;

  line_state_monitor #(
    .SYNC_STAGES       (S),
    .FILTER_CYCLES     (F),
    .SQUELCH_THRESHOLD (SQ),
    .RESET_CYCLES      (RST_C),
    .SUSPEND_CYCLES    (SUSP)
  ) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_dp         (i_dp),
    .i_dn         (i_dn),
    .i_hs_mode    (i_hs_mode),
    .i_ls_mode    (i_ls_mode),
    .o_line_state (o_line_state),
    .o_se0        (o_se0),
    .o_se1        (o_se1),
    .o_j_state    (o_j_state),
    .o_k_state    (o_k_state),
    .o_ls_change  (o_ls_change),
    .o_squelch    (o_squelch),
    .o_bus_reset  (o_bus_reset),
    .o_in_reset   (o_in_reset),
    .o_suspend    (o_suspend),
    .o_resume     (o_resume)
  );

  // Bus state code for a raw pin pair: LS swaps the meaning of 01/10.
  function automatic logic [1:0] decode_ref(input logic [1:0] raw, input logic hs, input logic ls);
    if (raw == 2'b00 || raw == 2'b11) return raw;
    if (hs || !ls) return raw;
    return ~raw;
  endfunction

  function automatic logic [15:0] obs();
    return {4'h0, o_line_state, o_se0, o_se1, o_j_state, o_k_state,
            o_ls_change, o_squelch, o_bus_reset, o_in_reset, o_suspend, o_resume};
  endfunction

  function automatic logic [15:0] exp_out();
    logic [1:0] ls;
    ls = decode_ref(m_filt, i_hs_mode, i_ls_mode);
    return {4'h0, ls, ls == 2'b00, ls == 2'b11, ls == 2'b10, ls == 2'b01,
            m_change, m_squelch, m_bus_reset, m_in_reset, m_suspend, m_resume};
  endfunction

  function automatic void model_reset();
    m_filt = 2'b00; m_dur = 0;
    m_change = 0; m_squelch = 0; m_bus_reset = 0;
    m_in_reset = 0; m_suspend = 0; m_resume = 0;
    pin_q = '{2'b00, 2'b00};
    flt_q = {};
  endfunction

  // One rising edge: events come from the state seen before the edge, then the
  // pin history advances.
  function automatic void model_edge();
    logic [1:0] cur;
    logic [1:0] synced;
    bit stable;
    cur = decode_ref(m_filt, i_hs_mode, i_ls_mode);
    m_squelch   = i_hs_mode && cur == 2'b00 && m_dur >= SQ;
    m_bus_reset = 0;
    m_resume    = 0;
    if (m_in_reset) begin
      if (cur != 2'b00) m_in_reset = 0;
    end else if (m_suspend) begin
      if (cur != 2'b10) begin
        m_suspend = 0;
        m_resume  = (cur == 2'b01);
      end
    end else if (cur == 2'b00 && m_dur == RST_C) begin
      m_bus_reset = 1;
      m_in_reset  = 1;
    end else if (cur == 2'b10 && !i_hs_mode && m_dur == SUSP) begin
      m_suspend = 1;
    end
    pin_q.push_back({i_dp, i_dn});
    synced = pin_q[pin_q.size() - 1 - S];
    if (pin_q.size() > S + 1) pin_q.delete(0);
    flt_q.push_back(synced);
    if (flt_q.size() > F) flt_q.delete(0);
    stable = (flt_q.size() == F);
    foreach (flt_q[i]) if (flt_q[i] != flt_q[0]) stable = 0;
    m_change = stable && (flt_q[0] != m_filt);
    if (m_change) begin
      m_filt = flt_q[0];
      m_dur  = 1;
    end else if (m_dur < DUR_MAX) begin
      m_dur++;
    end
  endfunction

  task automatic step();
    @(posedge i_clk);
    if (i_rst_n) model_edge();
    @(negedge i_clk);
  endtask

  task automatic test_reset();
    i_dp = 1; i_dn = 0; i_hs_mode = 0; i_ls_mode = 0; i_rst_n = 0;
    model_reset();
    repeat (3) @(negedge i_clk);
    checks++; if (o_line_state !== 2'b00) begin errors++; $display("FAIL reset_line_state: got %b want 00", o_line_state); end
    checks++; if ({o_se0, o_se1, o_j_state, o_k_state} !== 4'b1000) begin errors++; $display("FAIL reset_decode: got %b want 1000", {o_se0, o_se1, o_j_state, o_k_state}); end
    checks++; if ({o_ls_change, o_squelch, o_bus_reset, o_in_reset, o_suspend, o_resume} !== 6'b0) begin errors++; $display("FAIL reset_events: got %b want 000000", {o_ls_change, o_squelch, o_bus_reset, o_in_reset, o_suspend, o_resume}); end
    i_rst_n = 1;
    repeat (8) begin
      step();
      checks++; if (obs() !== exp_out()) begin errors++; $display("FAIL reset_release: got %h want %h", obs(), exp_out()); end
    end
  endtask

  task automatic test_fs_change();
    int lat = -1;
    int pulses = 0;
    i_dp = 0; i_dn = 1;
    for (int c = 1; c <= 12; c++) begin
      step();
      checks++; if (obs() !== exp_out()) begin errors++; $display("FAIL fs_change model: got %h want %h", obs(), exp_out()); end
      if (o_ls_change) pulses++;
      if (lat < 0 && o_line_state == 2'b01) lat = c;
    end
    checks++; if (lat != S + F) begin errors++; $display("FAIL fs_change latency: got %0d want %0d", lat, S + F); end
    checks++; if (pulses != 1) begin errors++; $display("FAIL fs_change pulses: got %0d want 1", pulses); end
    checks++; if (o_k_state !== 1'b1) begin errors++; $display("FAIL fs_change k_state: got %b want 1", o_k_state); end
  endtask

  task automatic test_glitch();
    int pulses = 0;
    int off_j = 0;
    bit saw_se0 = 0;
    i_dp = 1; i_dn = 0;
    repeat (8) begin
      step();
      checks++; if (obs() !== exp_out()) begin errors++; $display("FAIL glitch settle: got %h want %h", obs(), exp_out()); end
    end
    for (int c = 0; c < 10; c++) begin
      {i_dp, i_dn} = (c == 0) ? 2'b00 : 2'b10;
      step();
      checks++; if (obs() !== exp_out()) begin errors++; $display("FAIL glitch1 model: got %h want %h", obs(), exp_out()); end
      if (o_ls_change) pulses++;
      if (o_line_state != 2'b10) off_j++;
    end
    checks++; if (pulses != 0 || off_j != 0) begin errors++; $display("FAIL glitch1 reported: got pulses=%0d off_j=%0d want 0 0", pulses, off_j); end
    for (int c = 0; c < 10; c++) begin
      {i_dp, i_dn} = (c < 2) ? 2'b00 : 2'b10;
      step();
      checks++; if (obs() !== exp_out()) begin errors++; $display("FAIL glitch2 model: got %h want %h", obs(), exp_out()); end
      if (o_se0) saw_se0 = 1;
    end
    checks++; if (!saw_se0) begin errors++; $display("FAIL glitch2 se0: got 0 want 1"); end
  endtask

  task automatic test_hs_reset();
    int n = 0, sq_first = -1, br_first = -1, br_cnt = 0;
    bit cleared = 0;
    i_hs_mode = 1; i_dp = 1; i_dn = 0;
    repeat (8) begin
      step();
      checks++; if (obs() !== exp_out()) begin errors++; $display("FAIL hs settle: got %h want %h", obs(), exp_out()); end
    end
    i_dp = 0; i_dn = 0;
    for (int c = 0; c < 18; c++) begin
      step();
      checks++; if (obs() !== exp_out()) begin errors++; $display("FAIL hs_se0 model: got %h want %h", obs(), exp_out()); end
      if (o_se0 && o_ls_change) n = 1; else if (n > 0) n++;
      if (n > 0 && o_squelch && sq_first < 0) sq_first = n;
      if (o_bus_reset) begin br_cnt++; if (br_first < 0) br_first = n; end
    end
    checks++; if (sq_first != SQ + 1) begin errors++; $display("FAIL hs squelch_cycle: got %0d want %0d", sq_first, SQ + 1); end
    checks++; if (br_first != RST_C + 1 || br_cnt != 1) begin errors++; $display("FAIL hs bus_reset: got cycle=%0d count=%0d want %0d 1", br_first, br_cnt, RST_C + 1); end
    checks++; if (o_in_reset !== 1'b1) begin errors++; $display("FAIL hs in_reset: got %b want 1", o_in_reset); end
    i_dp = 1; i_dn = 0;
    for (int c = 0; c < 12; c++) begin
      step();
      checks++; if (obs() !== exp_out()) begin errors++; $display("FAIL hs_exit model: got %h want %h", obs(), exp_out()); end
      if (!o_in_reset) begin cleared = 1; break; end
    end
    checks++; if (!cleared || o_squelch !== 1'b0) begin errors++; $display("FAIL hs in_reset_clear: got cleared=%0d squelch=%b want 1 0", cleared, o_squelch); end
    i_hs_mode = 0;
  endtask

  task automatic test_suspend();
    int n = 0, su_first = -1, resumes = 0, br_cnt = 0;
    bit found = 0;
    i_hs_mode = 0; i_ls_mode = 0; i_dp = 0; i_dn = 1;
    repeat (8) begin
      step();
      checks++; if (obs() !== exp_out()) begin errors++; $display("FAIL susp settle: got %h want %h", obs(), exp_out()); end
    end
    i_dp = 1; i_dn = 0;
    for (int c = 0; c < 40; c++) begin
      step();
      checks++; if (obs() !== exp_out()) begin errors++; $display("FAIL susp_j model: got %h want %h", obs(), exp_out()); end
      if (o_j_state && o_ls_change) n = 1; else if (n > 0) n++;
      if (o_suspend) begin su_first = n; break; end
    end
    checks++; if (su_first != SUSP + 1) begin errors++; $display("FAIL susp enter_cycle: got %0d want %0d", su_first, SUSP + 1); end
    i_dp = 0; i_dn = 1;
    for (int c = 0; c < 10; c++) begin
      step();
      checks++; if (obs() !== exp_out()) begin errors++; $display("FAIL susp_k model: got %h want %h", obs(), exp_out()); end
      if (!o_suspend) begin found = 1; break; end
    end
    checks++; if (!found || o_resume !== 1'b1) begin errors++; $display("FAIL susp resume: got left=%0d resume=%b want 1 1", found, o_resume); end
    step();
    checks++; if (o_resume !== 1'b0) begin errors++; $display("FAIL susp resume_width: got %b want 0", o_resume); end
    i_dp = 1; i_dn = 0;
    for (int c = 0; c < 40; c++) begin
      step();
      checks++; if (obs() !== exp_out()) begin errors++; $display("FAIL susp_j2 model: got %h want %h", obs(), exp_out()); end
      if (o_suspend) break;
    end
    checks++; if (o_suspend !== 1'b1) begin errors++; $display("FAIL susp reenter: got %b want 1", o_suspend); end
    i_dp = 0; i_dn = 0;
    found = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      checks++; if (obs() !== exp_out()) begin errors++; $display("FAIL susp_se0 model: got %h want %h", obs(), exp_out()); end
      if (o_resume) resumes++;
      if (!o_suspend) begin found = 1; break; end
    end
    checks++; if (!found || resumes != 0) begin errors++; $display("FAIL susp se0_exit: got left=%0d resumes=%0d want 1 0", found, resumes); end
    for (int c = 0; c < 12; c++) begin
      step();
      checks++; if (obs() !== exp_out()) begin errors++; $display("FAIL susp_then_reset model: got %h want %h", obs(), exp_out()); end
      if (o_bus_reset) br_cnt++;
    end
    checks++; if (br_cnt != 1) begin errors++; $display("FAIL susp se0_bus_reset: got %0d want 1", br_cnt); end
    i_dp = 1; i_dn = 0;
    repeat (8) step();
  endtask

  task automatic test_ls_mode();
    int pulses = 0;
    i_hs_mode = 0; i_ls_mode = 1; i_dp = 0; i_dn = 1;
    repeat (8) begin
      step();
      checks++; if (obs() !== exp_out()) begin errors++; $display("FAIL ls settle: got %h want %h", obs(), exp_out()); end
    end
    checks++; if (o_j_state !== 1'b1) begin errors++; $display("FAIL ls j_state: got %b want 1", o_j_state); end
    #2 i_ls_mode = 0;
    #1;
    checks++; if (o_k_state !== 1'b1 || o_ls_change !== 1'b0) begin errors++; $display("FAIL ls mode_flip: got k=%b chg=%b want 1 0", o_k_state, o_ls_change); end
    @(negedge i_clk);
    repeat (4) begin
      step();
      checks++; if (obs() !== exp_out()) begin errors++; $display("FAIL ls after_flip: got %h want %h", obs(), exp_out()); end
      if (o_ls_change) pulses++;
    end
    checks++; if (pulses != 0) begin errors++; $display("FAIL ls flip_pulse: got %0d want 0", pulses); end
  endtask

  task automatic test_async_reset();
    int first = -1;
    i_hs_mode = 0; i_ls_mode = 0; i_dp = 0; i_dn = 1;
    repeat (8) step();
    i_dp = 1; i_dn = 0;
    for (int c = 0; c < 40; c++) begin
      step();
      if (o_suspend) break;
    end
    checks++; if (o_suspend !== 1'b1) begin errors++; $display("FAIL arst pre_suspend: got %b want 1", o_suspend); end
    #3 i_rst_n = 0;
    model_reset();
    #1;
    checks++; if (obs() !== 16'h0200) begin errors++; $display("FAIL arst mid_suspend: got %h want 0200", obs()); end
    @(negedge i_clk);
    i_rst_n = 1;
    for (int c = 1; c <= 40; c++) begin
      step();
      checks++; if (obs() !== exp_out()) begin errors++; $display("FAIL arst resuspend model: got %h want %h", obs(), exp_out()); end
      if (o_suspend) begin first = c; break; end
    end
    checks++; if (first != S + F + SUSP) begin errors++; $display("FAIL arst resuspend_edge: got %0d want %0d", first, S + F + SUSP); end
    i_dp = 0; i_dn = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (o_in_reset) break;
    end
    checks++; if (o_in_reset !== 1'b1) begin errors++; $display("FAIL arst pre_in_reset: got %b want 1", o_in_reset); end
    #3 i_rst_n = 0;
    model_reset();
    #1;
    checks++; if (obs() !== 16'h0200) begin errors++; $display("FAIL arst mid_bus_reset: got %h want 0200", obs()); end
    i_dp = 1; i_dn = 0;
    @(negedge i_clk);
    i_rst_n = 1;
    repeat (10) begin
      step();
      checks++; if (obs() !== exp_out()) begin errors++; $display("FAIL arst release2: got %h want %h", obs(), exp_out()); end
    end
  endtask

  task automatic test_random();
    int run = 0;
    for (int c = 0; c < 1500; c++) begin
      if (run == 0) begin
        {i_dp, i_dn} = 2'($urandom);
        run = ($urandom_range(0, 3) == 0) ? int'($urandom_range(15, 35)) : int'($urandom_range(1, 5));
        if ($urandom_range(0, 15) == 0) i_hs_mode = ~i_hs_mode;
        if ($urandom_range(0, 15) == 0) i_ls_mode = ~i_ls_mode;
      end
      run--;
      step();
      checks++; if (obs() !== exp_out()) begin errors++; $display("FAIL random cycle %0d: got %h want %h", c, obs(), exp_out()); end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_fs_change();
    test_glitch();
    test_hs_reset();
    test_suspend();
    test_ls_mode();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/line_state_monitor.md
Name: line_state_monitor

Overview:
Parametrised successor to the PHY line-state detector. Synchronises D+/D- through a configurable synchroniser chain and applies a glitch filter. Decodes the filtered state into J/K/SE0/SE1 for LS, FS and HS signalling. Times line-state durations to report squelch, USB bus reset, suspend and resume to the link/UTMI layer.

Parameters:
SYNC_STAGES, 2, synchroniser flops per line; legal range >=2.
FILTER_CYCLES, 2, consecutive identical samples required before the filtered state updates; legal range >=1.
SQUELCH_THRESHOLD, 3, HS SE0 cycles before o_squelch asserts.
RESET_CYCLES, 150, SE0 cycles recognised as bus reset (2.5 us at 60 MHz).
SUSPEND_CYCLES, 180000, non-HS idle-J cycles recognised as suspend (3 ms at 60 MHz).
CNT_W, $clog2(SUSPEND_CYCLES+1), duration counter width; localparam, not overridable.
Required ordering: SQUELCH_THRESHOLD < RESET_CYCLES < SUSPEND_CYCLES.

Ports:
i_clk  in  1  PHY clock
i_rst_n  in  1  asynchronous active-low reset
i_dp  in  1  raw D+ (asynchronous)
i_dn  in  1  raw D- (asynchronous)
i_hs_mode  in  1  high-speed signalling active
i_ls_mode  in  1  low-speed signalling (J/K polarity swapped); ignored when i_hs_mode=1
o_line_state  out  2  filtered state: 00 SE0, 01 K, 10 J, 11 SE1
o_se0, o_se1, o_j_state, o_k_state  out  1 each  one-hot decode of o_line_state
o_ls_change  out  1  one-cycle pulse when the filtered state changes
o_squelch  out  1  HS squelch level
o_bus_reset  out  1  one-cycle pulse on bus-reset detection
o_in_reset  out  1  level, high from bus-reset detection until SE0 ends
o_suspend  out  1  level, high while suspended
o_resume  out  1  one-cycle pulse when K leaves suspend

Behaviour:
- Reset (asynchronous, any time, including mid-operation): sync chain=0, filtered raw=00, o_line_state=SE0, o_se0=1, all other outputs 0, counters 0, FSM=ST_ACTIVE.
- Sync: {dp,dn} passes SYNC_STAGES flops.
- Filter:
  - Holds a candidate and a stability count.
  - When the synchronised value differs from the candidate: candidate is reloaded and count=1.
  - When the value equals the candidate and differs from the filtered value: count increments; when count reaches FILTER_CYCLES, filtered value <= candidate and o_ls_change pulses.
  - A pin change that is stable appears on o_line_state exactly SYNC_STAGES+FILTER_CYCLES rising edges after first sampling.
  - A glitch shorter than FILTER_CYCLES synchronised cycles is never reported.
- Decode (combinational from the filtered raw value):
  - 00 -> SE0; 11 -> SE1.
  - HS or FS: 10 -> J, 01 -> K.
  - LS (i_ls_mode=1, i_hs_mode=0): 01 -> J, 10 -> K.
  - A mode change re-decodes in the same cycle and does not pulse o_ls_change.
- Duration counter dur_cnt (CNT_W bits):
  - Loads 1 on a filtered change, otherwise increments.
  - Saturates at all-ones and never wraps.
- Squelch (registered):
  - Asserts the cycle after dur_cnt reaches SQUELCH_THRESHOLD while SE0 and i_hs_mode=1.
  - Clears the cycle after the filtered state leaves SE0 or i_hs_mode falls.
- FSM (enum in package), states ST_ACTIVE, ST_RESET, ST_SUSPEND:
  - ACTIVE -> RESET: SE0 with dur_cnt==RESET_CYCLES (any mode). Registered result: o_bus_reset pulses once and o_in_reset=1 on the following cycle.
  - ACTIVE -> SUSPEND: J with dur_cnt==SUSPEND_CYCLES and i_hs_mode=0. o_suspend=1 the following cycle.
  - RESET -> ACTIVE: filtered state leaves SE0. o_in_reset clears the next cycle. SE0 held past the threshold gives no second pulse.
  - SUSPEND -> ACTIVE on K: o_resume pulses once and o_suspend clears in the same cycle.
  - SUSPEND -> ACTIVE on SE0 or SE1: o_suspend clears and there is no o_resume. That SE0 is timed from its own start and may then trigger reset.
- Simultaneous events: the change is evaluated before the threshold test. A state change in the cycle a threshold would be reached cancels the event.
- HS idle SE0 therefore yields o_squelch first; if it persists, o_bus_reset follows. The link arbitrates.

Decomposition:
- Package usb_phy_pkg:
  - line_state_e (LS_SE0=2'b00, LS_K=2'b01, LS_J=2'b10, LS_SE1=2'b11)
  - lsm_state_e (ST_ACTIVE, ST_RESET, ST_SUSPEND)
  - timing default constants
- Sub-module line_sync_filter: parameters SYNC_STAGES and FILTER_CYCLES; outputs filtered raw {dp,dn} and the change pulse. Reused by the chirp detector.
- The top level holds decode, dur_cnt, squelch and the FSM.

Test Plan:
Sim parameters for all scenarios: SYNC_STAGES=2, FILTER_CYCLES=2, SQUELCH_THRESHOLD=3, RESET_CYCLES=8, SUSPEND_CYCLES=20.
1. FS, pins 10 -> 01 stable: o_line_state 10 -> 01 exactly 4 edges later; one o_ls_change pulse; o_k_state=1.
2. FS J, then a 1-cycle 00 glitch: o_line_state stays 10 with no o_ls_change. Repeat with the glitch held 2 cycles: SE0 is reported.
3. HS, pins 00 held 12 cycles: o_squelch=1 from filtered-SE0 cycle 4; o_bus_reset single pulse at cycle 9; o_in_reset high until pins return to 10, then clears.
4. FS, pins 10 held 25 cycles: o_suspend=1 at filtered cycle 21. Then pins 01: o_resume pulse and o_suspend=0 in the same cycle. Repeat exiting with 00: no o_resume.
5. LS mode, pins 01: o_j_state=1. Toggle i_ls_mode to 0 with pins static: o_k_state=1 the same cycle and no o_ls_change.
6. Assert i_rst_n=0 mid-suspend and mid-bus-reset: all outputs reach reset values immediately. After release, 20 further J cycles are needed to re-suspend.
